// File: rtl/awmc_pkg.sv
// Shared stage/mode encodings and helpers for the programmable washing-machine controller.
// The optional PREWASH stage is enabled with AWMC_PREWASH_EN. Its code is reserved here in every build.
package awmc_pkg;

    typedef enum logic [3:0] {
        ST_FILL    = 4'h0,
        ST_WASH    = 4'h1,
        ST_RINSE   = 4'h2,
        ST_SPIN    = 4'h3,
        ST_DONE    = 4'h4,
        ST_PREWASH = 4'h5,
        ST_PAUSE   = 4'h6,
        ST_FAULT   = 4'h7,
        ST_IDLE    = 4'hF
    } stage_e;

    localparam logic [1:0] MODE_QUICK  = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b01;
    localparam logic [1:0] MODE_HEAVY  = 2'b10;

    // Mode 2'b11 is folded onto normal.
    function automatic logic [2:0] rinse_target(input logic [1:0] mode, input logic [2:0] max_rinses);
        case (mode)
            MODE_QUICK:  return 3'd1;
            MODE_HEAVY:  return max_rinses;
            default:     return 3'd2;
        endcase
    endfunction

    // Stages with the drum turning; the lid must stay locked in these.
    function automatic logic is_active(input stage_e st);
        return (st == ST_PREWASH) || (st == ST_WASH) || (st == ST_RINSE) || (st == ST_SPIN);
    endfunction

endpackage

// File: rtl/awmc_if.sv
// Panel/sensor-to-controller bundle. master = panel/sensor side, slave = controller.
interface awmc_if;
    logic       tick;
    logic       start;
    logic       pause;
    logic       abort;
    logic       lid_closed;
    logic       water_full;
    logic [1:0] mode;
    logic [3:0] stage;
    logic       input_valve;
    logic       output_drain;
    logic       motor;
    logic       lid_lock;
    logic       done;
    logic       fault;

    modport master (
        output tick, start, pause, abort, lid_closed, water_full, mode,
        input  stage, input_valve, output_drain, motor, lid_lock, done, fault
    );

    modport slave (
        input  tick, start, pause, abort, lid_closed, water_full, mode,
        output stage, input_valve, output_drain, motor, lid_lock, done, fault
    );
endinterface

// File: rtl/awmc_stage_timer.sv
// Tick-qualified stage counter: clear, load-from-saved, saturating count, and terminal-count strobe.
module awmc_stage_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last,
    output logic [CNT_W-1:0] o_cnt,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_tc
);
    logic [CNT_W-1:0] r_cnt;

    assign o_cnt = r_cnt;
    assign o_tc  = i_en && (r_cnt == i_last);

    // Count stops at i_last; the stage logic decides what the terminal count means.
    always_comb begin
        o_cnt_nxt = r_cnt;
        if (i_clr)
            o_cnt_nxt = '0;
        else if (i_load)
            o_cnt_nxt = i_load_val;
        else if (i_en && (r_cnt != i_last))
            o_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else
            r_cnt <= o_cnt_nxt;
    end
endmodule

// File: rtl/awmc_prog.sv
// Programmable washing-machine sequencer: FILL, [PREWASH], WASH, N x RINSE, SPIN, DONE with pause/resume and fill fault.
// Define AWMC_PREWASH_EN to build in the PREWASH stage; otherwise FILL goes straight to WASH.
//   state   | meaning
//   IDLE    | waiting for start with lid closed
//   FILL    | valve open until water_full, FILL_T ticks then FAULT
//   PREWASH | motor on for PREWASH_T ticks (optional)
//   WASH    | motor on for WASH_T ticks
//   RINSE   | per pass: drain first half, valve second half, motor throughout
//   SPIN    | motor and drain for SPIN_T ticks
//   DONE    | one clk, then IDLE with done held
//   PAUSE   | actuators off, stage/count/pass held until start
//   FAULT   | fill timeout; leaves only on abort or reset
module awmc_prog
    import awmc_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FILL_T     = 20,
    parameter int PREWASH_T  = 8,
    parameter int WASH_T     = 30,
    parameter int RINSE_T    = 10,
    parameter int SPIN_T     = 12,
    parameter int MAX_RINSES = 3
) (
    input  logic   clk,
    input  logic   reset_n,
    awmc_if.slave  bus
);
    localparam logic [CNT_W-1:0] L_FILL  = CNT_W'(FILL_T - 1);
    localparam logic [CNT_W-1:0] L_WASH  = CNT_W'(WASH_T - 1);
    localparam logic [CNT_W-1:0] L_RINSE = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0] L_SPIN  = CNT_W'(SPIN_T - 1);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'(RINSE_T / 2);

    if ((RINSE_T % 2) != 0 || RINSE_T < 2 || MAX_RINSES < 1 || MAX_RINSES > 7 ||
        FILL_T < 1 || PREWASH_T < 1 || WASH_T < 1 || SPIN_T < 1 ||
        FILL_T >= (1 << CNT_W) || PREWASH_T >= (1 << CNT_W) || WASH_T >= (1 << CNT_W) ||
        RINSE_T >= (1 << CNT_W) || SPIN_T >= (1 << CNT_W)) begin : g_bad_params
        $error("awmc_prog: invalid timing/rinse parameters");
    end

    stage_e           r_stage, r_sav_stage, w_nxt, w_sav_nxt;
    logic [CNT_W-1:0] r_sav_cnt, w_cnt, w_cnt_nxt, w_last;
    logic [2:0]       r_pass, r_target, w_pass_nxt;
    logic             r_valve, r_drain, r_motor, r_lock, r_done, r_fault;
    logic             w_hold_req, w_run, w_en, w_tc, w_clr, w_load, w_accept, w_pause_entry;

    assign w_hold_req    = bus.pause || !bus.lid_closed;
    assign w_run         = (r_stage == ST_FILL) || is_active(r_stage);
    assign w_en          = bus.tick && w_run && !w_hold_req && !bus.abort;
    assign w_accept      = (r_stage == ST_IDLE) && (w_nxt == ST_FILL);
    assign w_pause_entry = (w_nxt == ST_PAUSE) && (r_stage != ST_PAUSE);
    // Pause entry/exit must not disturb the count; every other stage change or pass end restarts it.
    assign w_clr  = bus.abort || w_tc ||
                    ((w_nxt != r_stage) && (w_nxt != ST_PAUSE) && (r_stage != ST_PAUSE));
    assign w_load = (r_stage == ST_PAUSE) && (w_nxt != ST_PAUSE);

    always_comb begin
        w_last = '0;
        case (r_stage)
            ST_FILL:    w_last = L_FILL;
`ifdef AWMC_PREWASH_EN
            ST_PREWASH: w_last = CNT_W'(PREWASH_T - 1);
`endif
            ST_WASH:    w_last = L_WASH;
            ST_RINSE:   w_last = L_RINSE;
            ST_SPIN:    w_last = L_SPIN;
            default:    w_last = '0;
        endcase
    end

    awmc_stage_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (r_sav_cnt),
        .i_en       (w_en),
        .i_last     (w_last),
        .o_cnt      (w_cnt),
        .o_cnt_nxt  (w_cnt_nxt),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_nxt      = r_stage;
        w_pass_nxt = r_pass;
        if (bus.abort) begin
            w_nxt      = ST_IDLE;
            w_pass_nxt = '0;
        end else begin
            case (r_stage)
                ST_IDLE: begin
                    if (bus.start && bus.lid_closed) begin
                        w_nxt      = ST_FILL;
                        w_pass_nxt = '0;
                    end
                end
                ST_DONE:  w_nxt = ST_IDLE;
                ST_PAUSE: if (bus.start && !w_hold_req) w_nxt = r_sav_stage;
                ST_FAULT: w_nxt = ST_FAULT;
                default: begin
                    if (!w_run)
                        w_nxt = ST_IDLE;
                    else if (w_hold_req)
                        w_nxt = ST_PAUSE;
                    else begin
                        case (r_stage)
                            ST_FILL: begin
                                if (bus.water_full)
`ifdef AWMC_PREWASH_EN
                                    w_nxt = ST_PREWASH;
`else
                                    w_nxt = ST_WASH;
`endif
                                else if (w_tc)
                                    w_nxt = ST_FAULT;
                            end
`ifdef AWMC_PREWASH_EN
                            ST_PREWASH: if (w_tc) w_nxt = ST_WASH;
`endif
                            ST_WASH: if (w_tc) w_nxt = ST_RINSE;
                            ST_RINSE: begin
                                if (w_tc) begin
                                    if (3'(r_pass + 3'd1) == r_target) begin
                                        w_nxt      = ST_SPIN;
                                        w_pass_nxt = '0;
                                    end else begin
                                        w_pass_nxt = 3'(r_pass + 3'd1);
                                    end
                                end
                            end
                            ST_SPIN: if (w_tc) w_nxt = ST_DONE;
                            default: w_nxt = r_stage;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_sav_nxt = r_sav_stage;
        if (bus.abort)
            w_sav_nxt = ST_IDLE;
        else if (w_pause_entry)
            w_sav_nxt = r_stage;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage     <= ST_IDLE;
            r_sav_stage <= ST_IDLE;
            r_sav_cnt   <= '0;
            r_pass      <= '0;
            r_target    <= '0;
            r_valve     <= 1'b0;
            r_drain     <= 1'b0;
            r_motor     <= 1'b0;
            r_lock      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_stage     <= w_nxt;
            r_sav_stage <= w_sav_nxt;
            r_pass      <= w_pass_nxt;
            if (bus.abort)
                r_sav_cnt <= '0;
            else if (w_pause_entry)
                r_sav_cnt <= w_cnt;
            if (w_accept)
                r_target <= rinse_target(bus.mode, 3'(MAX_RINSES));
            r_valve <= (w_nxt == ST_FILL) || ((w_nxt == ST_RINSE) && (w_cnt_nxt >= HALF));
            r_drain <= ((w_nxt == ST_RINSE) && (w_cnt_nxt < HALF)) || (w_nxt == ST_SPIN);
            r_motor <= is_active(w_nxt);
            r_lock  <= is_active(w_nxt) || ((w_nxt == ST_PAUSE) && is_active(w_sav_nxt));
            if (bus.abort || w_accept)
                r_done <= 1'b0;
            else if (w_nxt == ST_DONE)
                r_done <= 1'b1;
            r_fault <= (w_nxt == ST_FAULT);
        end
    end

    assign bus.stage        = r_stage;
    assign bus.input_valve  = r_valve;
    assign bus.output_drain = r_drain;
    assign bus.motor        = r_motor;
    assign bus.lid_lock     = r_lock;
    assign bus.done         = r_done;
    assign bus.fault        = r_fault;
endmodule

// File: tb/tb_awmc_prog.sv
// Directed scoreboard bench for awmc_prog (default build, PREWASH disabled).
module tb_awmc_prog;
    import awmc_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    awmc_if u_if ();

    awmc_prog u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    // Actuator vector order: {valve, drain, motor, lid_lock, done, fault}
    localparam logic [5:0] A_OFF   = 6'b000000;
    localparam logic [5:0] A_FILL  = 6'b100000;
    localparam logic [5:0] A_MOT   = 6'b001100;
    localparam logic [5:0] A_RD    = 6'b011100;
    localparam logic [5:0] A_RV    = 6'b101100;
    localparam logic [5:0] A_SP    = 6'b011100;
    localparam logic [5:0] A_DONE  = 6'b000010;
    localparam logic [5:0] A_FAULT = 6'b000001;
    localparam logic [5:0] A_LOCK  = 6'b000100;

    typedef struct {
        string      tag;
        logic [9:0] val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function logic [9:0] observed();
        return {u_if.stage, u_if.input_valve, u_if.output_drain, u_if.motor,
                u_if.lid_lock, u_if.done, u_if.fault};
    endfunction

    task automatic expect_out(input string tag, input logic [3:0] st, input logic [5:0] act);
        exp_t e;
        e.tag = tag;
        e.val = {st, act};
        q.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [9:0] obs;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", observed());
            return;
        end
        e   = q.pop_front();
        obs = observed();
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed stage=%h act=%b expected stage=%h act=%b",
                   e.tag, obs[9:6], obs[5:0], e.val[9:6], e.val[5:0]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            u_if.tick = 1'b1;
            cyc();
            u_if.tick = 1'b0;
            if (i != n - 1) cyc();
        end
    endtask

    task automatic tick_chk(input int n, input string tag, input logic [3:0] st, input logic [5:0] act);
        expect_out(tag, st, act);
        ticks(n);
        check_out();
    endtask

    task automatic cyc_chk(input string tag, input logic [3:0] st, input logic [5:0] act);
        expect_out(tag, st, act);
        cyc();
        check_out();
    endtask

    task automatic start_chk(input string tag, input logic [3:0] st, input logic [5:0] act);
        expect_out(tag, st, act);
        u_if.start = 1'b1;
        cyc();
        u_if.start = 1'b0;
        check_out();
    endtask

    task automatic abort_chk(input string tag, input logic [3:0] st, input logic [5:0] act, input logic with_start);
        expect_out(tag, st, act);
        u_if.abort = 1'b1;
        u_if.start = with_start;
        cyc();
        u_if.abort = 1'b0;
        u_if.start = 1'b0;
        check_out();
    endtask

    task automatic fill_to_wash();
        u_if.water_full = 1'b1;
        cyc();
        u_if.water_full = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.tick       = 1'b0;
        u_if.start      = 1'b0;
        u_if.pause      = 1'b0;
        u_if.abort      = 1'b0;
        u_if.lid_closed = 1'b1;
        u_if.water_full = 1'b0;
        u_if.mode       = 2'b00;

        expect_out("reset", ST_IDLE, A_OFF);
        repeat (3) @(posedge clk);
        #1;
        check_out();
        reset_n = 1'b1;
        cyc();

        // Quick cycle, water_full three ticks into FILL
        u_if.mode = 2'b00;
        start_chk("quick_fill", ST_FILL, A_FILL);
        ticks(3);
        u_if.water_full = 1'b1;
        cyc_chk("quick_full", ST_WASH, A_MOT);
        u_if.water_full = 1'b0;
        tick_chk(29, "wash_last", ST_WASH, A_MOT);
        tick_chk(1, "rinse_entry", ST_RINSE, A_RD);
        tick_chk(4, "rinse_drain", ST_RINSE, A_RD);
        tick_chk(1, "rinse_valve", ST_RINSE, A_RV);
        tick_chk(4, "rinse_last", ST_RINSE, A_RV);
        tick_chk(1, "quick_spin", ST_SPIN, A_SP);
        tick_chk(11, "spin_last", ST_SPIN, A_SP);
        tick_chk(1, "quick_done", ST_DONE, A_DONE);
        cyc_chk("done_idle", ST_IDLE, A_DONE);
        cyc_chk("done_held", ST_IDLE, A_DONE);

        // Heavy: three passes, drain->valve at tick 5 of each
        u_if.mode = 2'b10;
        start_chk("heavy_fill_done_clr", ST_FILL, A_FILL);
        fill_to_wash();
        tick_chk(30, "heavy_rinse", ST_RINSE, A_RD);
        for (int p = 0; p < 3; p++) begin
            tick_chk(4, "heavy_pre_toggle", ST_RINSE, A_RD);
            tick_chk(1, "heavy_toggle", ST_RINSE, A_RV);
            if (p < 2) tick_chk(5, "heavy_next_pass", ST_RINSE, A_RD);
            else       tick_chk(5, "heavy_spin", ST_SPIN, A_SP);
        end
        tick_chk(12, "heavy_done", ST_DONE, A_DONE);
        cyc();

        // Pause at WASH tick 17 with a coincident tick, exact resume
        u_if.mode = 2'b01;
        start_chk("pause_fill", ST_FILL, A_FILL);
        fill_to_wash();
        ticks(17);
        u_if.pause = 1'b1;
        tick_chk(1, "pause_enter", ST_PAUSE, A_LOCK);
        tick_chk(3, "pause_hold", ST_PAUSE, A_LOCK);
        start_chk("pause_start_drop", ST_PAUSE, A_LOCK);
        u_if.pause = 1'b0;
        cyc_chk("pause_release", ST_PAUSE, A_LOCK);
        start_chk("pause_resume", ST_WASH, A_MOT);
        tick_chk(12, "resume_wash", ST_WASH, A_MOT);
        tick_chk(1, "resume_exit", ST_RINSE, A_RD);
        abort_chk("abort_rinse", ST_IDLE, A_OFF, 1'b0);

        // Lid opened during SPIN
        u_if.mode = 2'b00;
        start_chk("lid_fill", ST_FILL, A_FILL);
        fill_to_wash();
        ticks(30);
        ticks(10);
        tick_chk(4, "lid_spin", ST_SPIN, A_SP);
        u_if.lid_closed = 1'b0;
        cyc_chk("lid_pause", ST_PAUSE, A_LOCK);
        start_chk("lid_start_drop", ST_PAUSE, A_LOCK);
        u_if.lid_closed = 1'b1;
        cyc_chk("lid_closed_wait", ST_PAUSE, A_LOCK);
        start_chk("lid_resume", ST_SPIN, A_SP);
        tick_chk(7, "lid_spin_rem", ST_SPIN, A_SP);
        tick_chk(1, "lid_done", ST_DONE, A_DONE);
        cyc();
        u_if.lid_closed = 1'b0;
        start_chk("idle_lid_open", ST_IDLE, A_DONE);
        u_if.lid_closed = 1'b1;

        // Fill timeout, then abort
        start_chk("fault_fill", ST_FILL, A_FILL);
        tick_chk(19, "fill_last", ST_FILL, A_FILL);
        tick_chk(1, "fill_timeout", ST_FAULT, A_FAULT);
        start_chk("fault_start_ign", ST_FAULT, A_FAULT);
        abort_chk("fault_abort", ST_IDLE, A_OFF, 1'b0);

        // water_full on the timeout tick wins; abort beats start
        start_chk("race_fill", ST_FILL, A_FILL);
        ticks(19);
        u_if.water_full = 1'b1;
        tick_chk(1, "full_beats_timeout", ST_WASH, A_MOT);
        u_if.water_full = 1'b0;
        abort_chk("abort_start_wash", ST_IDLE, A_OFF, 1'b1);
        abort_chk("abort_start_idle", ST_IDLE, A_OFF, 1'b1);

        // Asynchronous reset mid-RINSE
        start_chk("rst_fill", ST_FILL, A_FILL);
        fill_to_wash();
        ticks(30);
        tick_chk(3, "pre_reset", ST_RINSE, A_RD);
        expect_out("async_reset", ST_IDLE, A_OFF);
        #2;
        reset_n = 1'b0;
        #1;
        check_out();
        cyc();
        reset_n = 1'b1;
        cyc();
        start_chk("post_reset_fill", ST_FILL, A_FILL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
